// File: rtl/rom_arbiter.sv
// Two-port arbiter/sequencer in front of the asynchronous instruction ROM.
// Define ROM_ARB_RR_EN for round-robin arbitration; the default is fixed priority (port 0 first).
module rom_arbiter #(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ROM_DEPTH   = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [ADDR_W:0] LP_DEPTH    = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [3:0]      LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e              r_state;
  logic [3:0]          r_cnt;
  logic                r_gnt1;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;
  logic                r_rom_cs;
  logic [ADDR_W-1:0]   r_rom_addr;
  logic                r_busy;

  logic                w_gnt1;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_in_range;

`ifdef ROM_ARB_RR_EN
  // r_ptr names the port that wins the next tie
  logic r_ptr;
  assign w_gnt1 = req1 & (~req0 | r_ptr);
`else
  assign w_gnt1 = req1 & ~req0;
`endif

  assign w_addr     = w_gnt1 ? addr1 : addr0;
  assign w_in_range = {1'b0, w_addr} < LP_DEPTH;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_gnt1     <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
`ifdef ROM_ARB_RR_EN
      r_ptr      <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req0 | req1) begin
            r_gnt1     <= w_gnt1;
            r_rom_addr <= w_addr;
            r_busy     <= 1'b1;
`ifdef ROM_ARB_RR_EN
            r_ptr      <= ~w_gnt1;
`endif
            if (w_in_range) begin
              r_rom_cs <= 1'b1;
              r_cnt    <= LP_CNT_INIT;
              r_state  <= StAccess;
            end else begin
              // Out-of-range reads never touch the ROM and complete next cycle
              r_rdata <= '0;
              r_err   <= 1'b1;
              r_ack0  <= ~w_gnt1;
              r_ack1  <= w_gnt1;
              r_state <= StResp;
            end
          end
        end
        StAccess: begin
          if (r_cnt == 4'd0) begin
            r_rdata  <= rom_data;
            r_err    <= 1'b0;
            r_ack0   <= ~r_gnt1;
            r_ack1   <= r_gnt1;
            r_rom_cs <= 1'b0;
            r_state  <= StResp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata    = r_rdata;
  assign err      = r_err;
  assign rom_cs   = r_rom_cs;
  assign rom_addr = r_rom_addr;
  assign busy     = r_busy;

endmodule

// File: tb/tb_rom_arbiter.sv
// Scoreboard bench for rom_arbiter: drivers push expected words per port, a monitor
// pops them on each ack and checks data, ROM select window and arbitration decision.
module tb_rom_arbiter;

  localparam int unsigned W = 3;
`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [5:0]  addr0, addr1;
  logic        ack0, ack1, err, rom_cs, busy;
  logic [31:0] rdata;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data;
  logic [31:0] rom_mem [32];

  always #5 clk = ~clk;

  // Unselected ROM output is modelled as garbage so stale sampling shows up
  assign rom_data = rom_cs ? rom_mem[rom_addr[4:0]] : 32'hBADC_0FFE;

  rom_arbiter #(
    .ADDR_W     (6),
    .DATA_W     (32),
    .ROM_DEPTH  (32),
    .WAIT_CYCLES(W)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .addr0   (addr0),
    .ack0    (ack0),
    .req1    (req1),
    .addr1   (addr1),
    .ack1    (ack1),
    .rdata   (rdata),
    .err     (err),
    .rom_cs  (rom_cs),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .busy    (busy)
  );

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_order[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       hist0 [1024];
  logic       hist1 [1024];
  int         cyc      = 0;
  int         cs_run   = 0;
  logic [5:0] cs_addr  = '0;
  int         last_gnt = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (a >= 6'd32);
    e.data = e.err ? 32'h0 : rom_mem[a[4:0]];
    return e;
  endfunction

  function automatic logic [5:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(32, 63));
    return 6'($urandom_range(0, 31));
  endfunction

  task automatic handle_ack(input int p);
    exp_t e;
    int   g;
    logic mine, other;
    int   winner;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_ack: port %0d acked, expected no ack", p);
      return;
    end
    if (p == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check("rdata", rdata, e.data);
    check("err", err, e.err);
    check("cs_in_ack", rom_cs, 0);
    if (e.err) begin
      check("cs_run_oor", cs_run, 0);
      g = cyc - 1;
    end else begin
      check("cs_run", cs_run, W);
      check("cs_addr", cs_addr, e.addr);
      g = cyc - int'(W) - 1;
    end
    mine  = (p == 0) ? hist0[g % 1024] : hist1[g % 1024];
    other = (p == 0) ? hist1[g % 1024] : hist0[g % 1024];
    check("granted_req", mine, 1);
    if (other) begin
      winner = RR ? 1 - last_gnt : 0;
      check("tie_winner", p, winner);
    end
    last_gnt = p;
    ack_order.push_back(p);
  endtask

  always @(negedge clk) begin
    cyc++;
    hist0[cyc % 1024] = req0;
    hist1[cyc % 1024] = req1;
    if (!reset_n) begin
      cs_run   = 0;
      last_gnt = 1;
    end else begin
      check("busy", busy, rom_cs | ack0 | ack1);
      if (ack0 | ack1) check("ack_overlap", ack0 & ack1, 0);
      if (ack0) handle_ack(0);
      if (ack1) handle_ack(1);
      if (rom_cs) begin
        if (cs_run > 0 && rom_addr != cs_addr) cs_run = 1;
        else cs_run++;
        cs_addr = rom_addr;
      end else begin
        cs_run = 0;
      end
    end
  end

  // Called at posedge+1; returns the cycle count from request to ack.
  task automatic do_req(input int p, input logic [5:0] a, input int gap, output int lat);
    bit ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    if (p == 0) begin q0.push_back(model(a)); addr0 = a; req0 = 1'b1; end
    else        begin q1.push_back(model(a)); addr1 = a; req1 = 1'b1; end
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((p == 0) ? ack0 : ack1) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d got no ack, expected ack within 200 cycles", p);
    end
    @(posedge clk);
    #1;
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l0, l1, lat;
    int exp_order [4];
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    for (int i = 0; i < 32; i++) rom_mem[i] = $urandom;
    rom_mem[5] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ack0, ack1, err, rom_cs, busy, rom_addr, rdata}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Tie from reset: port 0 first, port 1 served WAIT_CYCLES+2 later
    ack_order.delete();
    fork
      do_req(0, 6'd1, 0, l0);
      do_req(1, 6'd2, 0, l1);
    join
    check("tie_lat0", l0, W + 1);
    check("tie_lat1", l1, 2 * W + 3);
    check("tie_first", ack_order[0], 0);

    // Single read, lone requester
    do_req(0, 6'd5, 0, lat);
    check("single_lat", lat, W + 1);

    // Out of range on port 1
    do_req(1, 6'd40, 0, lat);
    check("oor_lat", lat, 1);

    // Both ports back-to-back for two requests each
    ack_order.delete();
    if (RR) begin
      exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    end else begin
      exp_order[0] = 0; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 1;
    end
    fork
      begin
        int la;
        for (int k = 0; k < 2; k++) do_req(0, 6'(3 + k), 0, la);
      end
      begin
        int lb;
        for (int k = 0; k < 2; k++) do_req(1, 6'(10 + k), 0, lb);
      end
    join
    check("order_len", ack_order.size(), 4);
    for (int i = 0; i < 4; i++) check("grant_order", ack_order[i], exp_order[i]);

    // Reset during an access aborts it; the held request is served afresh
    q0.push_back(model(6'd7));
    addr0 = 6'd7;
    req0  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("cs_before_reset", rom_cs, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("cs_async_drop", rom_cs, 0);
    check("busy_async_drop", busy, 0);
    check("ack_async_drop", ack0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    lat = 0;
    for (int i = 0; i < 50 && !ack0; i++) begin
      @(negedge clk);
      if (!ack0) lat++;
    end
    check("lat_after_reset", lat, W + 1);
    @(posedge clk);
    #1;
    req0 = 1'b0;

    // Randomized traffic on both ports
    fork
      begin
        int lr0;
        for (int k = 0; k < 40; k++) do_req(0, rand_addr(), int'($urandom_range(0, 4)), lr0);
      end
      begin
        int lr1;
        for (int k = 0; k < 40; k++) do_req(1, rand_addr(), int'($urandom_range(0, 4)), lr1);
      end
    join

    repeat (10) @(posedge clk);
    #1;
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
